// File: rtl/gate_chain_sequencer_pkg.sv
// Shared types and constants for the gate-chain sequencer.
// Elements are signed Q2.16 fixed point.
package gate_chain_sequencer_pkg;

    localparam int W    = 19;
    localparam int FRAC = 16;

    localparam logic [W-1:0] FIX_ONE = 19'h10000;

    typedef logic signed [W-1:0] elem_t;
    typedef elem_t [1:0][1:0]    mtx2_t;

    // Packed order is [1][1], [1][0], [0][1], [0][0].
    localparam mtx2_t IDENT = {FIX_ONE, {W{1'b0}}, {W{1'b0}}, FIX_ONE};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_ISSUE,
        S_WAIT,
        S_OUTPUT
    } state_e;

endpackage

// File: rtl/gate_chain_sequencer_matrix_multiplier.sv
// Two-cycle 2x2 fixed-point matrix multiplier: r = a * b.
// done_o rises two cycles after the start_i cycle.
module matrix_multiplier #(
    parameter int W    = 19,
    parameter int FRAC = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [1:0][1:0][W-1:0] a_i,
    input  logic [1:0][1:0][W-1:0] b_i,
    output logic [1:0][1:0][W-1:0] r_o,
    output logic                   done_o
);

    logic [1:0][1:0][W-1:0] prod_d;
    logic [1:0][1:0][W-1:0] prod_q;
    logic [1:0][1:0][W-1:0] r_q;
    logic                   v1_q;
    logic                   done_q;

    function automatic logic [W-1:0] mac(
        input logic signed [W-1:0] a0,
        input logic signed [W-1:0] b0,
        input logic signed [W-1:0] a1,
        input logic signed [W-1:0] b1
    );
        logic signed [2*W:0] s;
        s = a0 * b0 + a1 * b1;
        return s[W+FRAC-1:FRAC];
    endfunction

    always_comb begin
        prod_d = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                prod_d[i][j] = mac(a_i[i][0], b_i[0][j],
                                   a_i[i][1], b_i[1][j]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            r_q    <= '0;
            v1_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            v1_q   <= start_i;
            done_q <= v1_q;
            if (start_i) prod_q <= prod_d;
            if (v1_q)    r_q    <= prod_q;
        end
    end

    assign r_o    = r_q;
    assign done_o = done_q;

endmodule

// File: rtl/gate_chain_sequencer.sv
// Composes a chain of 2x2 gates into acc = g_n * ... * g_1
// using an external multiplier on the mul_* ports.
module gate_chain_sequencer #(
    parameter int W       = 19,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic                   gate_valid_i,
    output logic                   gate_ready_o,
    input  logic [1:0][1:0][W-1:0] gate_mtx_i,
    input  logic                   gate_last_i,
    output logic [1:0][1:0][W-1:0] mul_a_o,
    output logic [1:0][1:0][W-1:0] mul_b_o,
    output logic                   mul_ready_o,
    input  logic [1:0][1:0][W-1:0] mul_r_i,
    input  logic                   mul_completed_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [1:0][1:0][W-1:0] res_mtx_o,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       gate_count_o,
    output logic                   err_timeout_o
);

    import gate_chain_sequencer_pkg::*;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] ONE_W = W'(FIX_ONE);
    localparam logic [1:0][1:0][W-1:0] ID_M =
        {ONE_W, {W{1'b0}}, {W{1'b0}}, ONE_W};

    state_e                 state_q, state_d;
    logic [1:0][1:0][W-1:0] acc_q, acc_d;
    logic [1:0][1:0][W-1:0] gate_q, gate_d;
    logic                   last_q, last_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [TW-1:0]          tmo_q, tmo_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= ID_M;
            gate_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            gate_q  <= gate_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        gate_d  = gate_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        // start overrides everything, dropping any in-flight product
        if (start_i) begin
            state_d = S_ACCEPT;
            acc_d   = ID_M;
            cnt_d   = '0;
            err_d   = 1'b0;
            tmo_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_ACCEPT: begin
                    if (gate_valid_i) begin
                        gate_d  = gate_mtx_i;
                        last_d  = gate_last_i;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (mul_completed_i) begin
                        acc_d = mul_r_i;
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                        state_d = last_q ? S_OUTPUT : S_ACCEPT;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_OUTPUT;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (res_ready_i) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign gate_ready_o  = (state_q == S_ACCEPT);
    assign mul_ready_o   = (state_q == S_ISSUE);
    assign res_valid_o   = (state_q == S_OUTPUT);
    assign busy_o        = (state_q != S_IDLE);
    assign mul_a_o       = gate_q;
    assign mul_b_o       = acc_q;
    assign res_mtx_o     = acc_q;
    assign gate_count_o  = cnt_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_gate_chain_sequencer.sv
// Directed bench for gate_chain_sequencer with the
// matrix_multiplier attached on the mul_* ports.
module tb_gate_chain_sequencer;

    import gate_chain_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic        gate_valid_i = 1'b0;
    logic        gate_ready_o;
    mtx2_t       gate_mtx_i = '0;
    logic        gate_last_i = 1'b0;
    mtx2_t       mul_a_o, mul_b_o, mul_r_i, mm_r;
    logic        mul_ready_o;
    logic        mul_completed_i;
    logic        mm_done;
    logic        block_done = 1'b0;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;
    mtx2_t       res_mtx_o;
    logic        busy_o;
    logic [7:0]  gate_count_o;
    logic        err_timeout_o;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign mul_r_i         = mm_r;
    assign mul_completed_i = mm_done & ~block_done;

    gate_chain_sequencer #(.W(19), .CNT_W(8), .TIMEOUT(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .gate_valid_i    (gate_valid_i),
        .gate_ready_o    (gate_ready_o),
        .gate_mtx_i      (gate_mtx_i),
        .gate_last_i     (gate_last_i),
        .mul_a_o         (mul_a_o),
        .mul_b_o         (mul_b_o),
        .mul_ready_o     (mul_ready_o),
        .mul_r_i         (mul_r_i),
        .mul_completed_i (mul_completed_i),
        .res_valid_o     (res_valid_o),
        .res_ready_i     (res_ready_i),
        .res_mtx_o       (res_mtx_o),
        .busy_o          (busy_o),
        .gate_count_o    (gate_count_o),
        .err_timeout_o   (err_timeout_o)
    );

    matrix_multiplier #(.W(19), .FRAC(16)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start_i (mul_ready_o),
        .a_i     (mul_a_o),
        .b_i     (mul_b_o),
        .r_o     (mm_r),
        .done_o  (mm_done)
    );

    function automatic mtx2_t mk(input logic [18:0] e00, e01, e10, e11);
        mtx2_t m;
        m[0][0] = e00;
        m[0][1] = e01;
        m[1][0] = e10;
        m[1][1] = e11;
        return m;
    endfunction

    localparam logic [18:0] ONE = 19'h10000;
    localparam logic [18:0] NEG = 19'h70000;

    mtx2_t mx_i, mx_x, mx_z, mx_zx;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h exp %h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send_gate(input mtx2_t m, input logic last);
        int n;
        n = 0;
        gate_mtx_i   = m;
        gate_last_i  = last;
        gate_valid_i = 1'b1;
        while (!gate_ready_o && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("gate_ready_timeout", 0, 1);
        tick();
        gate_valid_i = 1'b0;
        gate_last_i  = 1'b0;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!res_valid_o && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("res_valid_timeout", 0, 1);
    endtask

    task automatic take_res();
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
    endtask

    initial begin
        int n;
        mx_i  = mk(ONE, 0, 0, ONE);
        mx_x  = mk(0, ONE, ONE, 0);
        mx_z  = mk(ONE, 0, 0, NEG);
        mx_zx = mk(0, ONE, NEG, 0);

        repeat (3) tick();
        chk("rst_gate_ready", gate_ready_o, 0);
        chk("rst_mul_ready", mul_ready_o, 0);
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_count", gate_count_o, 0);
        chk("rst_err", err_timeout_o, 0);
        chk("rst_acc", res_mtx_o, mx_i);
        chk("rst_gate", mul_a_o, 0);
        reset = 1'b0;
        tick();

        // gate_valid in IDLE is ignored
        gate_valid_i = 1'b1;
        gate_mtx_i   = mx_x;
        repeat (3) tick();
        chk("idle_gate_ready", gate_ready_o, 0);
        chk("idle_busy", busy_o, 0);
        gate_valid_i = 1'b0;

        // Scenario 1: single X
        pulse_start();
        chk("s1_ready", gate_ready_o, 1);
        chk("s1_busy", busy_o, 1);
        send_gate(mx_x, 1'b1);
        chk("s1_mul_ready", mul_ready_o, 1);
        chk("s1_mul_a", mul_a_o, mx_x);
        chk("s1_mul_b", mul_b_o, mx_i);
        tick();
        chk("s1_mul_ready_1cyc", mul_ready_o, 0);
        chk("s1_mul_a_hold", mul_a_o, mx_x);
        wait_res(n);
        chk("s1_res", res_mtx_o, mx_x);
        chk("s1_count", gate_count_o, 1);
        chk("s1_err", err_timeout_o, 0);
        take_res();
        chk("s1_idle", busy_o, 0);
        chk("s1_res_drop", res_valid_o, 0);

        // Scenario 2: X then X, with accept-to-ready latency
        pulse_start();
        send_gate(mx_x, 1'b0);
        n = 0;
        while (!gate_ready_o && n < 20) begin
            tick();
            n++;
        end
        chk("s2_latency", n, 3);
        chk("s2_mid_acc", res_mtx_o, mx_x);
        chk("s2_mid_count", gate_count_o, 1);
        send_gate(mx_x, 1'b1);
        wait_res(n);
        chk("s2_res", res_mtx_o, mx_i);
        chk("s2_count", gate_count_o, 2);

        // start during OUTPUT drops res_valid
        pulse_start();
        chk("out_start_drop", res_valid_o, 0);
        chk("out_start_ready", gate_ready_o, 1);
        chk("out_start_acc", res_mtx_o, mx_i);

        // Scenario 3 and 4: X then Z, held result
        send_gate(mx_x, 1'b0);
        send_gate(mx_z, 1'b1);
        wait_res(n);
        for (int i = 0; i < 5; i++) begin
            chk("s4_valid_hold", res_valid_o, 1);
            chk("s4_res_hold", res_mtx_o, mx_zx);
            chk("s4_busy_hold", busy_o, 1);
            tick();
        end
        chk("s3_count", gate_count_o, 2);
        take_res();
        chk("s4_idle", busy_o, 0);

        // Scenario 5: start in WAIT discards the late product
        pulse_start();
        send_gate(mx_x, 1'b0);
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("s5_late_done", mm_done, 1);
        chk("s5_ready", gate_ready_o, 1);
        chk("s5_acc", res_mtx_o, mx_i);
        chk("s5_count", gate_count_o, 0);
        tick();
        chk("s5_acc_after", res_mtx_o, mx_i);
        send_gate(mx_z, 1'b1);
        wait_res(n);
        chk("s5_res", res_mtx_o, mx_z);
        chk("s5_res_count", gate_count_o, 1);
        take_res();

        // Scenario 6: multiplier never completes
        block_done = 1'b1;
        pulse_start();
        send_gate(mx_x, 1'b1);
        wait_res(n);
        chk("s6_tmo_cycles", n, 9);
        chk("s6_err", err_timeout_o, 1);
        chk("s6_acc", res_mtx_o, mx_i);
        chk("s6_count", gate_count_o, 0);
        take_res();
        block_done = 1'b0;
        chk("s6_err_sticky", err_timeout_o, 1);
        pulse_start();
        chk("s6_err_clear", err_timeout_o, 0);

        // reset mid-chain abandons the chain
        send_gate(mx_x, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_acc", res_mtx_o, mx_i);
        chk("rst_mid_count", gate_count_o, 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (res_valid_o || busy_o) n++;
            tick();
        end
        chk("rst_mid_quiet", n, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
